// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
module hilo_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic             is_signed,
   input  logic             mt_hi,
   input  logic             mt_lo,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             div_by_zero
);
   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] m, a_raw, a_mag, b_mag, q, r, hi_nx, lo_nx;
   logic [2*WIDTH-1:0] acc, acc_nx, prod;
   logic [WIDTH:0] mul_sum, rem_sh, diff;
   logic is_div, neg_q, neg_r, dz, a_neg, b_neg, muldiv_req, accept, mt_wr, fix_wr;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = flush ? IDLE :
                 state == IDLE ? (accept ? RUN : IDLE) :
                 state == RUN ? (cnt == CNT_W'(WIDTH-1) ? FIX : RUN) : IDLE;
   always_comb begin
      muldiv_req = start & (op == 2'b01 | op == 2'b10);
      busy = state != IDLE;
      stall = busy | (muldiv_req & ~flush);
      accept = state == IDLE & muldiv_req & ~flush;
      mt_wr = state == IDLE & start & op == 2'b11 & ~flush;
      fix_wr = state == FIX & ~flush;
   end
   always_comb begin
      a_neg = is_signed & src_a[WIDTH-1];
      b_neg = is_signed & src_b[WIDTH-1];
      a_mag = a_neg ? -src_a : src_a;
      b_mag = b_neg ? -src_b : src_b;
      // multiply adds m into the upper half; divide trial-subtracts m from the shifted remainder
      mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
      rem_sh = acc[2*WIDTH-1:WIDTH-1];
      diff = rem_sh - {1'b0, m};
      acc_nx = !is_div ? {mul_sum, acc[WIDTH-1:1]} :
               diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                             {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      q = acc[WIDTH-1:0];
      r = acc[2*WIDTH-1:WIDTH];
      prod = neg_q ? -acc : acc;
      hi_nx = !is_div ? prod[2*WIDTH-1:WIDTH] : dz ? a_raw : neg_r ? -r : r;
      lo_nx = !is_div ? prod[WIDTH-1:0] : dz ? '1 : neg_q ? -q : q;
   end
   always_ff @(posedge clk)
      if (accept) begin
         is_div <= op == 2'b10;
         neg_q <= a_neg ^ b_neg;
         neg_r <= a_neg;
         dz <= src_b == '0;
         a_raw <= src_a;
         m <= op == 2'b10 ? b_mag : a_mag;
         acc <= {{WIDTH{1'b0}}, op == 2'b10 ? a_mag : b_mag};
      end else if (state == RUN) acc <= acc_nx;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         cnt <= '0;
         hi_out <= '0;
         lo_out <= '0;
         done <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         cnt <= accept ? '0 : state == RUN ? cnt + CNT_W'(1) : cnt;
         done <= fix_wr;
         div_by_zero <= fix_wr & is_div & dz;
         if (mt_wr & mt_hi) hi_out <= src_a;
         if (mt_wr & mt_lo) lo_out <= src_a;
         if (fix_wr) begin
            hi_out <= hi_nx;
            lo_out <= lo_nx;
         end
      end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: directed vectors and corner sequences for hilo_muldiv (WIDTH 32 and 8).
module tb_hilo_muldiv;
   logic clk = 0, resetn = 0, start = 0, start8 = 0, is_signed = 0, mt_hi = 0, mt_lo = 0, flush = 0;
   logic [1:0] op = 0;
   logic [31:0] src_a = 0, src_b = 0, hi_out, lo_out;
   logic [7:0] a8 = 0, b8 = 0, hi8, lo8;
   logic busy, stall, done, div_by_zero, busy8, stall8, done8, dz8;
   int checks = 0, failures = 0;

   hilo_muldiv #(.WIDTH(32)) u32 (.clk(clk), .resetn(resetn), .start(start), .op(op), .is_signed(is_signed),
      .mt_hi(mt_hi), .mt_lo(mt_lo), .src_a(src_a), .src_b(src_b), .flush(flush), .hi_out(hi_out),
      .lo_out(lo_out), .busy(busy), .stall(stall), .done(done), .div_by_zero(div_by_zero));
   hilo_muldiv #(.WIDTH(8)) u8 (.clk(clk), .resetn(resetn), .start(start8), .op(op), .is_signed(is_signed),
      .mt_hi(mt_hi), .mt_lo(mt_lo), .src_a(a8), .src_b(b8), .flush(flush), .hi_out(hi8),
      .lo_out(lo8), .busy(busy8), .stall(stall8), .done(done8), .div_by_zero(dz8));

   always #5 clk = ~clk;

   typedef struct {
      string name;
      logic [1:0] op;
      logic sgn;
      logic [31:0] a, b, hi, lo;
      logic dz;
   } vec_t;
   vec_t vecs[12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic s, input logic [31:0] a, input logic [31:0] b);
      op = o; is_signed = s; src_a = a; src_b = b; start = 1;
      #1 chk("stall_accept", stall, 1);
      @(posedge clk); #1;
      start = 0; op = 0;
      chk("busy_after_accept", busy, 1);
   endtask

   task automatic wait_done(output int lat);
      int drops = 0;
      lat = 0;
      while (!done && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (!done && !stall) drops++;
      end
      chk("stall_held", drops, 0);
   endtask

   task automatic mt(input logic h, input logic l, input logic [31:0] d);
      op = 2'b11; mt_hi = h; mt_lo = l; src_a = d; start = 1;
      @(posedge clk); #1;
      start = 0; op = 0; mt_hi = 0; mt_lo = 0;
   endtask

   initial begin
      int lat, seen;
      vecs[0]  = '{"multu_max", 2'b01, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0};
      vecs[1]  = '{"mult_m3x7", 2'b01, 1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0};
      vecs[2]  = '{"div_m7d2", 2'b10, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0};
      vecs[3]  = '{"divu_7d0", 2'b10, 0, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF, 1};
      vecs[4]  = '{"div_min_m1", 2'b10, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0};
      vecs[5]  = '{"multu_3x5", 2'b01, 0, 32'd3, 32'd5, 32'h0, 32'h0000000F, 0};
      vecs[6]  = '{"div_7dm2", 2'b10, 1, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 0};
      vecs[7]  = '{"divu_100d7", 2'b10, 0, 32'd100, 32'd7, 32'h2, 32'hE, 0};
      vecs[8]  = '{"mult_m1xm1", 2'b01, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 0};
      vecs[9]  = '{"div_m7d0", 2'b10, 1, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1};
      vecs[10] = '{"mult_minxmin", 2'b01, 1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 0};
      vecs[11] = '{"divu_max_d1", 2'b10, 0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'hFFFFFFFF, 0};

      #1;
      chk("rst_hi", hi_out, 0); chk("rst_lo", lo_out, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
      @(posedge clk); @(posedge clk); #1 resetn = 1;

      // back-to-back: each op after the first is issued in the previous op's done cycle
      for (int i = 0; i < 12; i++) begin
         issue(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b);
         wait_done(lat);
         chk({vecs[i].name, "_lat"}, lat, 33);
         chk({vecs[i].name, "_hi"}, hi_out, vecs[i].hi);
         chk({vecs[i].name, "_lo"}, lo_out, vecs[i].lo);
         chk({vecs[i].name, "_dz"}, div_by_zero, vecs[i].dz);
         chk({vecs[i].name, "_busy"}, busy, 0);
      end
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("dz_one_cycle", div_by_zero, 0);

      // MT writes on consecutive cycles
      op = 2'b11; mt_hi = 1; src_a = 32'h12345678; start = 1;
      @(posedge clk); #1;
      chk("mthi_val", hi_out, 32'h12345678); chk("mthi_busy", busy, 0);
      mt_hi = 0; mt_lo = 1; src_a = 32'h9ABCDEF0;
      @(posedge clk); #1;
      chk("mtlo_val", lo_out, 32'h9ABCDEF0); chk("mtlo_hi_kept", hi_out, 32'h12345678);
      chk("mt_busy", busy, 0); chk("mt_done", done, 0);
      start = 0; op = 0; mt_lo = 0;

      // flushed MT is dropped
      op = 2'b11; mt_hi = 1; mt_lo = 1; src_a = 32'h55555555; flush = 1; start = 1;
      @(posedge clk); #1;
      start = 0; op = 0; mt_hi = 0; mt_lo = 0; flush = 0;
      chk("flush_mt_hi", hi_out, 32'h12345678); chk("flush_mt_lo", lo_out, 32'h9ABCDEF0);

      // flushed mul request is not accepted and does not stall
      op = 2'b01; src_a = 5; src_b = 6; flush = 1; start = 1;
      #1 chk("flush_req_stall", stall, 0);
      @(posedge clk); #1;
      start = 0; op = 0; flush = 0;
      chk("flush_req_busy", busy, 0);

      // MTHI during a DIV is ignored
      issue(2'b10, 0, 32'd100, 32'd7);
      repeat (3) @(posedge clk);
      #1 mt(1, 0, 32'hDEADBEEF);
      wait_done(lat);
      chk("mt_during_div_done", done, 1);
      chk("mt_during_div_hi", hi_out, 32'h2); chk("mt_during_div_lo", lo_out, 32'hE);

      // flush in cycle 10 of a DIV
      mt(1, 0, 32'hAAAA0000);
      mt(0, 1, 32'h0000BBBB);
      issue(2'b10, 1, 32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      #1 flush = 1;
      @(posedge clk); #1 flush = 0;
      chk("flush_busy", busy, 0);
      seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("flush_no_done", seen, 0);
      chk("flush_hi", hi_out, 32'hAAAA0000); chk("flush_lo", lo_out, 32'h0000BBBB);

      // asynchronous reset mid-RUN
      mt(1, 1, 32'h11111111);
      issue(2'b01, 0, 32'd5, 32'd5);
      repeat (5) @(posedge clk);
      #3 resetn = 0;
      #1;
      chk("arst_hi", hi_out, 0); chk("arst_lo", lo_out, 0); chk("arst_busy", busy, 0); chk("arst_done", done, 0);
      @(posedge clk); #1 resetn = 1;
      @(posedge clk); #1;
      chk("arst_rel_hi", hi_out, 0); chk("arst_rel_busy", busy, 0); chk("arst_rel_done", done, 0);
      issue(2'b01, 0, 32'd3, 32'd5);
      wait_done(lat);
      chk("post_rst_lat", lat, 33);
      chk("post_rst_hi", hi_out, 0); chk("post_rst_lo", lo_out, 32'hF);

      // WIDTH = 8 build
      op = 2'b10; is_signed = 1; a8 = 8'h80; b8 = 8'hFF; start8 = 1;
      @(posedge clk); #1;
      start8 = 0; op = 0;
      lat = 0;
      while (!done8 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("w8_div_lat", lat, 9);
      chk("w8_div_lo", lo8, 8'h80); chk("w8_div_hi", hi8, 8'h00); chk("w8_div_dz", dz8, 0);
      op = 2'b01; is_signed = 1; a8 = 8'hFD; b8 = 8'h07; start8 = 1;
      @(posedge clk); #1;
      start8 = 0; op = 0;
      lat = 0;
      while (!done8 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("w8_mul_lat", lat, 9);
      chk("w8_mul_hi", hi8, 8'hFF); chk("w8_mul_lo", lo8, 8'hEB);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
